// File: rtl/dma_host_responder.sv
// Host-side DMA responder: answers line read/write handshakes from a local line array
// after programmable latencies, so the memory controller can run without a real host.
module dma_host_responder #(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64,
    parameter int DEPTH_LINES   = 64,
    parameter int RD_LATENCY    = 4,
    parameter int WR_LATENCY    = 2,
    parameter int INIT_DELAY    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_BITCOUNT-1:0] corrected_address,
    input  logic                     host_rgo,
    input  logic                     host_wgo,
    input  logic                     host_we,
    input  logic                     host_re,
    input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out,
    output logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in,
    output logic                     host_init,
    output logic                     host_rd_ready,
    output logic                     host_wr_ready,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count,
    output logic [31:0]              re_count,
    output logic                     addr_err
);
    // state     | meaning
    // S_INIT    | post-reset delay, requests ignored
    // S_IDLE    | waiting for host_rgo / host_wgo (read wins)
    // S_RD_WAIT | read latency countdown, aborts if host_rgo drops
    // S_RD_RESP | one-cycle host_rd_ready with registered line
    // S_WR_WAIT | write latency countdown, aborts if host_wgo drops
    // S_WR_OPEN | host_wr_ready held until host_we or host_wgo drop

    localparam int OFF = $clog2(CL_SIZE_WIDTH / 8);
    localparam int IDX = $clog2(DEPTH_LINES);
    localparam int MAX_RW = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int MAX_DLY = (INIT_DELAY > MAX_RW) ? INIT_DELAY : MAX_RW;
    localparam int CNT_W = $clog2(MAX_DLY) + 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_WAIT, S_RD_RESP, S_WR_WAIT, S_WR_OPEN
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX-1:0] rd_idx_q;
    logic rd_oor_q;
    logic [CL_SIZE_WIDTH-1:0] mem [DEPTH_LINES];

    logic [ADDR_BITCOUNT-1:0] addr_line;
    logic [IDX-1:0] addr_idx;
    logic addr_oor;
    logic init_set, cap_rd, rd_load, rd_done, wr_done, mem_we;

    // Low OFF bits select a byte within the line and are dropped by the shift.
    assign addr_line = corrected_address >> OFF;
    assign addr_idx  = addr_line[IDX-1:0];
    assign addr_oor  = (addr_line >> IDX) != '0;

    assign host_rd_ready = (state_q == S_RD_RESP);
    assign host_wr_ready = (state_q == S_WR_OPEN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        init_set = 1'b0;
        cap_rd   = 1'b0;
        rd_load  = 1'b0;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            S_INIT: begin
                if (cnt_q == '0) begin
                    init_set = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (host_rgo) begin
                    cap_rd  = 1'b1;
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = S_RD_WAIT;
                end else if (host_wgo) begin
                    cnt_d   = CNT_W'(WR_LATENCY - 1);
                    state_d = S_WR_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (!host_rgo) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    rd_load = 1'b1;
                    state_d = S_RD_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RD_RESP: begin
                rd_done = 1'b1;
                state_d = S_IDLE;
            end
            S_WR_WAIT: begin
                if (!host_wgo) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_WR_OPEN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_OPEN: begin
                // The address is taken in the strobe cycle, not at request time.
                if (host_we) begin
                    wr_done = 1'b1;
                    mem_we  = !addr_oor;
                    state_d = S_IDLE;
                end else if (!host_wgo) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= S_INIT;
            cnt_q                 <= CNT_W'(INIT_DELAY - 1);
            rd_idx_q              <= '0;
            rd_oor_q              <= 1'b0;
            host_data_bus_read_in <= '0;
            host_init             <= 1'b0;
            rd_count              <= '0;
            wr_count              <= '0;
            re_count              <= '0;
            addr_err              <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (init_set) host_init <= 1'b1;
            if (cap_rd) begin
                rd_idx_q <= addr_idx;
                rd_oor_q <= addr_oor;
            end
            if (rd_load) host_data_bus_read_in <= rd_oor_q ? '0 : mem[rd_idx_q];
            if (rd_done) begin
                rd_count <= rd_count + 32'd1;
                if (rd_oor_q) addr_err <= 1'b1;
            end
            if (wr_done) begin
                wr_count <= wr_count + 32'd1;
                if (addr_oor) addr_err <= 1'b1;
            end
            if (host_re) re_count <= re_count + 32'd1;
        end
    end

    // Line storage is deliberately unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_idx] <= host_data_bus_write_out;
    end

endmodule
